svc_uart_rx: RTL
================

Name: svc_uart_rx

Overview:
- 8N1 UART receiver; the receive end of the SoC's uart_tx line.
- Lets a bench or a second SoC instance decode console output (e.g. hello-world text) into bytes.
- Bytes are delivered on a valid/ready stream through a one-entry output buffer.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLOCK_FREQ_MHZ, 25, system clock frequency in MHz.
- BAUD_RATE, 115_200, serial bit rate.
- CLKS_PER_BIT, (CLOCK_FREQ_MHZ*1_000_000)/BAUD_RATE (floor), clocks per bit, derived; 217 at defaults.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- urx_in  input  1  serial line, idle high, asynchronous to clk.
- urx_valid  output  1  urx_data holds an unconsumed byte.
- urx_data  output  8  received byte.
- urx_ready  input  1  consumer accepts the byte when urx_valid && urx_ready.
- urx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- urx_overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Outputs: urx_valid=0, urx_data=0, urx_frame_err=0, urx_overrun=0.
  - Internal: synchronizer flops=1, state=IDLE, counters=0.
- Input synchronizer: urx_in passes through 2 flops, reset to 1. Only the synchronized value (rxs) is used.
- Bit counter: counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2 (floor), 108 at defaults.
- States:
  - IDLE: on rxs==0 -> START, counter=0.
  - START: when counter==HALF-1, sample rxs.
    - rxs==0 -> DATA, counter=0, bit index=0.
    - rxs==1 -> IDLE (glitch rejected, no flags).
  - DATA: when counter==CLKS_PER_BIT-1, sample rxs into shift register, LSB first. After bit index 7 -> STOP.
  - STOP: when counter==CLKS_PER_BIT-1, sample rxs.
    - Stop=1 and (!urx_valid or urx_ready this cycle): urx_data <= byte, urx_valid <= 1 next cycle, -> IDLE.
    - Stop=1, urx_valid && !urx_ready: urx_overrun pulses 1 cycle; buffer keeps the old byte; new byte discarded; -> IDLE.
    - Stop=0: urx_frame_err pulses 1 cycle; byte discarded; -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE. A held-low line yields exactly one frame_err.
- Latency:
  - Stop sample occurs HALF + 9*CLKS_PER_BIT clocks after the cycle rxs first reads 0 (2061 at defaults).
  - urx_valid rises 1 cycle after the stop sample; rxs lags the pin by 2 cycles.
- Buffer:
  - urx_valid stays high and urx_data stays stable until the handshake.
  - Handshake clears urx_valid next cycle, unless a new byte loads in the same cycle; then valid stays 1 with the new data.
- Re-arm: receiver returns to IDLE at mid-stop-bit, so back-to-back frames with zero idle are received.
- Reset mid-frame: returns everything to reset values immediately; a partial byte is never delivered.

Decomposition:
- Package svc_uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - function clks_per_bit(freq_mhz, baud);
  - UART_DATA_BITS=8 constant, shared with the transmitter.
- Sub-module: svc_sync, a generic 2-flop synchronizer with a reset-value parameter (used with reset value 1).
- FSM, counters and buffer live in svc_uart_rx.

Test Plan:
- Send 0x55 at 115200 baud with urx_ready=1 -> urx_valid pulses once, urx_data=0x55, no flags; valid exactly 2061±1 clocks after the synchronized falling edge.
- Send "Hi\n" (0x48, 0x69, 0x0A) back-to-back with no idle, ready=1 -> three handshakes in order, no flags.
- 50-clock low glitch on idle line -> no valid, no frame_err; a following 0xA5 is received correctly.
- 0xA5 with stop bit forced low, then line high, then 0x3C -> one urx_frame_err pulse, no valid for 0xA5, then valid with 0x3C.
- ready=0, send 0x11 then 0x22 -> valid with 0x11, one urx_overrun pulse at the second stop sample, data stays 0x11; after ready=1 the handshake occurs and valid drops.
- Assert rst_n low during data bit 4 of 0x77, release, send 0x99 -> outputs zero during reset, no 0x77 delivered, 0x99 received.

Source files
------------

// File: rtl/svc_uart_pkg.sv
// ----------------------------------------------------------------------------
// svc_uart_pkg
//
// Shared definitions for the SoC UART blocks.
//   - UART_DATA_BITS : payload width of one 8N1 frame, shared with uart_tx.
//   - uart_rx_state_e: receiver FSM states.
//   - clks_per_bit() : integer clocks per serial bit for a given clock/baud.
// ----------------------------------------------------------------------------
package svc_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Receiver states. BREAK parks the FSM after a framing error until the
    // line returns high, so a line held low reports only one error.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    // Truncating division; the residual baud error is tolerated by sampling
    // each bit at its middle.
    function automatic int clks_per_bit(input int freq_mhz, input int baud);
        return (freq_mhz * 1_000_000) / baud;
    endfunction

endpackage : svc_uart_pkg

// File: rtl/svc_sync.sv
// ----------------------------------------------------------------------------
// svc_sync
//
// Generic two-flop synchronizer for a single asynchronous input bit.
//
// Ports:
//   clk    in   destination clock
//   rst_n  in   asynchronous active-low reset; both flops load RESET_VAL
//   d      in   asynchronous input
//   q      out  synchronized copy of d, two clk cycles late
// ----------------------------------------------------------------------------
module svc_sync #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // The first flop may go metastable; only the second one is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : svc_sync

// File: rtl/svc_uart_rx.sv
// ----------------------------------------------------------------------------
// svc_uart_rx
//
// 8N1 UART receiver with a one-entry valid/ready output buffer.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   urx_in         in   serial line, idle high, asynchronous to clk
//   urx_valid      out  urx_data holds an unconsumed byte
//   urx_data[7:0]  out  received byte, stable while urx_valid is high
//   urx_ready      in   consumer takes the byte when urx_valid && urx_ready
//   urx_frame_err  out  one-cycle pulse: stop bit sampled low
//   urx_overrun    out  one-cycle pulse: finished byte dropped, buffer full
//
// The start bit is confirmed at its middle (HALF clocks after the falling
// edge); every later bit is then sampled one full bit period apart, which
// lands each sample mid-bit. The FSM returns to IDLE at mid-stop-bit, so a
// frame that follows with zero idle time is still caught.
// ----------------------------------------------------------------------------
module svc_uart_rx
    import svc_uart_pkg::*;
#(
    parameter int CLOCK_FREQ_MHZ = 25,
    parameter int BAUD_RATE      = 115_200,
    parameter int CLKS_PER_BIT   = clks_per_bit(CLOCK_FREQ_MHZ, BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       urx_in,
    output logic       urx_valid,
    output logic [7:0] urx_data,
    input  logic       urx_ready,
    output logic       urx_frame_err,
    output logic       urx_overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

    logic                      rxs;
    uart_rx_state_e            state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    // The line is idle high, so the synchronizer resets to 1 to avoid a
    // false start bit coming out of reset.
    svc_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (urx_in),
        .q     (rxs)
    );

    // Receiver FSM, bit timing and the output buffer. Flags default low
    // every cycle so each one is a single-cycle pulse. A handshake clears
    // urx_valid first; a byte completing in the same cycle overrides that
    // (later non-blocking assignment wins) and keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            urx_valid     <= 1'b0;
            urx_data      <= '0;
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;
        end else begin
            urx_frame_err <= 1'b0;
            urx_overrun   <= 1'b0;

            if (urx_valid && urx_ready) begin
                urx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                // A low shorter than half a bit is treated as a glitch.
                START: begin
                    if (cnt == CNT_HALF_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // LSB arrives first, so shift in from the top.
                DATA: begin
                    if (cnt == CNT_BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[UART_DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The buffer can take the byte if it is empty or is being
                // emptied by a handshake in this very cycle.
                STOP: begin
                    if (cnt == CNT_BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            if (!urx_valid || urx_ready) begin
                                urx_data  <= shreg;
                                urx_valid <= 1'b1;
                            end else begin
                                urx_overrun <= 1'b1;
                            end
                        end else begin
                            state         <= BREAK;
                            urx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : svc_uart_rx
